// File: rtl/layer_sched_pkg.sv
// Shared types and helpers for the digit-detector layer step scheduler.
package layer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERROR
    } sched_state_t;

    typedef enum logic {
        KIND_LOAD,
        KIND_COMPUTE
    } step_kind_t;

    // Step 1 loads the picture, even steps load weights; odd steps > 1 compute.
    function automatic logic step_is_load(input logic [31:0] s);
        return (s == 32'd1) || (s[0] == 1'b0);
    endfunction

    function automatic step_kind_t step_kind(input logic [31:0] s);
        return step_is_load(s) ? KIND_LOAD : KIND_COMPUTE;
    endfunction

endpackage

// File: rtl/step_watchdog.sv
// Per-step watchdog: counts WAIT cycles and flags the last allowed one.
module step_watchdog
    import layer_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned TMO_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);
    localparam logic             WD_ON = (TIMEOUT != 0);

    logic [TMO_W-1:0] count_q;

    // Cycle counter: restarted on every issue, advanced while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry is only meaningful while waiting; a zero TIMEOUT disables it.
    assign expired = WD_ON && enable && (count_q == LIMIT);

endmodule

// File: rtl/layer_step_scheduler.sv
// Top-level step sequencer: issues load/compute start pulses step by step
// and waits for the matching unit's done pulse, with watchdog and abort.
module layer_step_scheduler
    import layer_sched_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 15,
    parameter int unsigned STEP_W    = 5,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned TMO_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic              load_done,
    input  logic              conv_done,
    output logic [STEP_W-1:0] step,
    output logic              load_start,
    output logic              conv_start,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS);
    localparam logic [STEP_W-1:0] FIRST_STEP = STEP_W'(1);

    sched_state_t      state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d, step_inc;
    logic              load_start_q, load_start_d;
    logic              conv_start_q, conv_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              match_done;
    logic              wd_expired;
    step_kind_t        first_kind, next_kind;

    assign step_inc   = step_q + FIRST_STEP;
    assign first_kind = step_kind(32'd1);
    assign next_kind  = step_kind(32'(step_inc));
    // Only the done pulse of the unit that owns the current step counts.
    assign match_done = (step_kind(32'(step_q)) == KIND_LOAD) ? load_done : conv_done;

    step_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ISSUE),
        .enable  (state_q == WAIT),
        .expired (wd_expired)
    );

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        load_start_d = 1'b0;
        conv_start_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        if (abort) begin
            state_d = IDLE;
            step_d  = '0;
            busy_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d      = ISSUE;
                        step_d       = FIRST_STEP;
                        load_start_d = (first_kind == KIND_LOAD);
                        conv_start_d = (first_kind == KIND_COMPUTE);
                        busy_d       = 1'b1;
                        error_d      = 1'b0;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    // A matching done in the expiry cycle still advances.
                    if (match_done) begin
                        if (step_q == LAST_STEP) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d      = ISSUE;
                            step_d       = step_inc;
                            load_start_d = (next_kind == KIND_LOAD);
                            conv_start_d = (next_kind == KIND_COMPUTE);
                        end
                    end else if (wd_expired) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                ERROR: state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            load_start_q <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            load_start_q <= load_start_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign step       = step_q;
    assign load_start = load_start_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_layer_step_scheduler.sv
// Self-checking bench for layer_step_scheduler with a schedule-level model.
module tb_layer_step_scheduler;

    localparam int N   = 5;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0, abort = 1'b0, load_done = 1'b0, conv_done = 1'b0;
    logic [4:0] step;
    logic       load_start, conv_start, busy, done, error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-step response delays (cycles after start) and wrong-unit flags.
    int dly[1:N];
    bit wrong[1:N];

    // Observations from run_job.
    int st_cyc[$];
    bit st_load[$];
    int st_step[$];
    int dn_cyc[$];
    int busy_cyc[$];
    bit busy_val[$];
    int err_cyc, viol, go_cyc;

    // Model expectations.
    int ex_cyc[$];
    bit ex_load[$];
    int ex_done, ex_err, ex_end, ex_last;

    layer_step_scheduler #(
        .NUM_STEPS (N),
        .STEP_W    (5),
        .TIMEOUT   (TMO),
        .TMO_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .abort      (abort),
        .load_done  (load_done),
        .conv_done  (conv_done),
        .step       (step),
        .load_start (load_start),
        .conv_start (conv_start),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_is_load(input int s);
        return (s == 1) || (s % 2 == 0);
    endfunction

    // Schedule model: each step starts one cycle after the previous step's
    // done; a step whose unit needs more than TMO cycles errors at TMO+1.
    function automatic void build_expect();
        int t;
        ex_cyc.delete();
        ex_load.delete();
        ex_done = -1;
        ex_err  = -1;
        t = go_cyc + 1;
        for (int s = 1; s <= N; s++) begin
            ex_cyc.push_back(t);
            ex_load.push_back(model_is_load(s));
            if (dly[s] > TMO) begin
                ex_err  = t + TMO + 1;
                ex_end  = ex_err;
                ex_last = s;
                return;
            end
            t = t + dly[s] + 1;
        end
        ex_done = t;
        ex_end  = t;
        ex_last = N;
    endfunction

    // Pulses go, plays both units with the programmed delays, logs outputs.
    task automatic run_job(input int max_cycles, input bit go_noise);
        int  resp_c, wrong_c, s;
        bit  resp_ld, prev_start;
        st_cyc.delete(); st_load.delete(); st_step.delete();
        dn_cyc.delete(); busy_cyc.delete(); busy_val.delete();
        err_cyc = -1; viol = 0; resp_c = -1; wrong_c = -1;
        resp_ld = 1'b0; prev_start = 1'b0;
        @(negedge clk);
        go = 1'b1;
        go_cyc = cyc;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            go = 1'b0; load_done = 1'b0; conv_done = 1'b0;
            busy_cyc.push_back(cyc);
            busy_val.push_back(busy);
            if (load_start && conv_start) viol++;
            if (prev_start && (load_start || conv_start)) viol++;
            prev_start = load_start || conv_start;
            if (load_start || conv_start) begin
                s = int'(step);
                if (s < 1 || s > N) begin
                    viol++;
                    s = 1;
                end
                st_cyc.push_back(cyc);
                st_load.push_back(load_start);
                st_step.push_back(int'(step));
                resp_c  = cyc + dly[s];
                resp_ld = load_start;
                wrong_c = wrong[s] ? cyc + 1 : -1;
            end
            if (done) dn_cyc.push_back(cyc);
            if (error && err_cyc < 0) err_cyc = cyc;
            if (done || error) break;
            if (cyc == wrong_c) begin
                if (resp_ld) conv_done = 1'b1;
                else         load_done = 1'b1;
            end
            if (cyc == resp_c) begin
                if (resp_ld) load_done = 1'b1;
                else         conv_done = 1'b1;
            end
            if (go_noise && $urandom_range(0, 3) == 0) go = 1'b1;
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({step, load_start, conv_start, busy, done, error} !== 10'd0) begin
            bad++;
            $display("FAIL reset_hold: got step=%0d ls=%b cs=%b busy=%b done=%b err=%b want all 0",
                     step, load_start, conv_start, busy, done, error);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({step, load_start, conv_start, busy, done, error} !== 10'd0) begin
            bad++;
            $display("FAIL reset_release: got step=%0d ls=%b cs=%b busy=%b done=%b err=%b want all 0",
                     step, load_start, conv_start, busy, done, error);
        end
    endtask

    task automatic test_nominal();
        int got, bm;
        for (int s = 1; s <= N; s++) begin dly[s] = 3; wrong[s] = 1'b0; end
        run_job(100, 1'b0);
        build_expect();
        total++;
        if (st_cyc.size() !== ex_cyc.size()) begin
            bad++;
            $display("FAIL nominal_starts: got %0d want %0d", st_cyc.size(), ex_cyc.size());
        end
        for (int i = 0; i < ex_cyc.size() && i < st_cyc.size(); i++) begin
            total++;
            if (st_cyc[i] !== ex_cyc[i] || st_load[i] !== ex_load[i] || st_step[i] !== i + 1) begin
                bad++;
                $display("FAIL nominal_start%0d: got cyc=%0d load=%0d step=%0d want cyc=%0d load=%0d step=%0d",
                         i + 1, st_cyc[i], st_load[i], st_step[i], ex_cyc[i], ex_load[i], i + 1);
            end
        end
        got = (dn_cyc.size() == 1) ? dn_cyc[0] : -1;
        total++;
        if (got !== ex_done) begin
            bad++;
            $display("FAIL nominal_done_cycle: got %0d want %0d", got, ex_done);
        end
        total++;
        if (int'(step) !== N || busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL nominal_final: got step=%0d busy=%b err=%b want step=%0d busy=0 err=0",
                     step, busy, error, N);
        end
        bm = 0;
        for (int i = 0; i < busy_cyc.size(); i++)
            if (busy_val[i] !== (busy_cyc[i] >= go_cyc + 1 && busy_cyc[i] < ex_end)) bm++;
        total++;
        if (bm !== 0 || viol !== 0) begin
            bad++;
            $display("FAIL nominal_busy_protocol: got busy_err=%0d viol=%0d want 0 0", bm, viol);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || int'(step) !== N) begin
            bad++;
            $display("FAIL nominal_done_width: got done=%b step=%0d want done=0 step=%0d", done, step, N);
        end
    endtask

    task automatic test_wrong_unit();
        for (int s = 1; s <= N; s++) begin dly[s] = 3; wrong[s] = 1'b0; end
        dly[2] = 5;
        wrong[2] = 1'b1;
        run_job(100, 1'b0);
        build_expect();
        total++;
        if (st_cyc.size() < 3 || st_cyc[2] !== ex_cyc[2] || st_step[2] !== 3 || st_load[2] !== 1'b0) begin
            bad++;
            $display("FAIL wrong_unit_step3: got n=%0d cyc=%0d want cyc=%0d step=3 conv",
                     st_cyc.size(), (st_cyc.size() >= 3) ? st_cyc[2] : -1, ex_cyc[2]);
        end
        total++;
        if (dn_cyc.size() !== 1 || error !== 1'b0) begin
            bad++;
            $display("FAIL wrong_unit_done: got ndone=%0d err=%b want 1 0", dn_cyc.size(), error);
        end
    endtask

    task automatic test_timeout();
        int starts;
        for (int s = 1; s <= N; s++) begin dly[s] = 3; wrong[s] = 1'b0; end
        dly[2] = 20;
        run_job(100, 1'b0);
        build_expect();
        total++;
        if (err_cyc !== ex_err || st_cyc.size() !== 2) begin
            bad++;
            $display("FAIL timeout_cycle: got err_cyc=%0d starts=%0d want err_cyc=%0d starts=2",
                     err_cyc, st_cyc.size(), ex_err);
        end
        total++;
        if (int'(step) !== 2 || busy !== 1'b0 || error !== 1'b1 || dn_cyc.size() !== 0) begin
            bad++;
            $display("FAIL timeout_state: got step=%0d busy=%b err=%b done=%0d want 2 0 1 0",
                     step, busy, error, dn_cyc.size());
        end
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            if (load_start || conv_start) starts++;
        end
        total++;
        if (starts !== 0 || error !== 1'b1 || int'(step) !== 2) begin
            bad++;
            $display("FAIL timeout_go_ignored: got starts=%0d err=%b step=%0d want 0 1 2", starts, error, step);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++;
        if (error !== 1'b0 || step !== 5'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort: got err=%b step=%0d busy=%b want 0 0 0", error, step, busy);
        end
    endtask

    task automatic test_random_jobs();
        int got_d, bm, sm;
        for (int j = 0; j < 12; j++) begin
            for (int s = 1; s <= N; s++) begin
                dly[s] = $urandom_range(1, 8);
                if ($urandom_range(0, 5) == 0) dly[s] = TMO;
                wrong[s] = (dly[s] >= 2) && ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 3) == 0) dly[$urandom_range(1, N)] = $urandom_range(TMO + 1, TMO + 4);
            run_job(150, 1'b1);
            build_expect();
            sm = 0;
            for (int i = 0; i < ex_cyc.size() && i < st_cyc.size(); i++)
                if (st_cyc[i] !== ex_cyc[i] || st_load[i] !== ex_load[i] || st_step[i] !== i + 1) sm++;
            total++;
            if (st_cyc.size() !== ex_cyc.size() || sm !== 0) begin
                bad++;
                $display("FAIL random%0d_starts: got n=%0d bad=%0d want n=%0d bad=0",
                         j, st_cyc.size(), sm, ex_cyc.size());
            end
            got_d = (dn_cyc.size() == 1) ? dn_cyc[0] : -1;
            total++;
            if (got_d !== ex_done || err_cyc !== ex_err) begin
                bad++;
                $display("FAIL random%0d_end: got done=%0d err=%0d want done=%0d err=%0d",
                         j, got_d, err_cyc, ex_done, ex_err);
            end
            bm = 0;
            for (int i = 0; i < busy_cyc.size(); i++)
                if (busy_val[i] !== (busy_cyc[i] >= go_cyc + 1 && busy_cyc[i] < ex_end)) bm++;
            total++;
            if (bm !== 0 || viol !== 0 || int'(step) !== ex_last) begin
                bad++;
                $display("FAIL random%0d_busy_step: got busy_err=%0d viol=%0d step=%0d want 0 0 %0d",
                         j, bm, viol, step, ex_last);
            end
            if (error) begin
                @(negedge clk); abort = 1'b1;
                @(negedge clk); abort = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        int  resp_c, starts;
        bit  resp_ld, found;
        resp_c = -1; resp_ld = 1'b0; found = 1'b0;
        @(negedge clk); go = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            go = 1'b0; load_done = 1'b0; conv_done = 1'b0;
            if (conv_start && int'(step) == 3) begin
                abort = 1'b1;
                found = 1'b1;
            end else begin
                if (load_start || conv_start) begin resp_c = cyc + 2; resp_ld = load_start; end
                if (cyc == resp_c) begin
                    if (resp_ld) load_done = 1'b1;
                    else         conv_done = 1'b1;
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL abort_reach_step3: got no conv_start at step 3 within 60 cycles want one");
        end
        @(negedge clk);
        abort = 1'b0;
        conv_done = 1'b1;
        total++;
        if (step !== 5'd0 || busy !== 1'b0 || load_start || conv_start || error || done) begin
            bad++;
            $display("FAIL abort_in_issue: got step=%0d busy=%b ls=%b cs=%b want step=0 busy=0 no pulses",
                     step, busy, load_start, conv_start);
        end
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            conv_done = 1'b0;
            if (load_start || conv_start || busy) starts++;
        end
        total++;
        if (starts !== 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", starts);
        end
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        starts = 0;
        repeat (6) begin
            if (load_start || conv_start || busy || step !== 5'd0) starts++;
            @(negedge clk);
        end
        total++;
        if (starts !== 0) begin
            bad++;
            $display("FAIL abort_with_go: got %0d active cycles want 0", starts);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({step, load_start, conv_start, busy, done, error} !== 10'd0) begin
            bad++;
            $display("FAIL async_reset: got step=%0d ls=%b cs=%b busy=%b done=%b err=%b want all 0",
                     step, load_start, conv_start, busy, done, error);
        end
        @(negedge clk); rst = 1'b0;
        for (int s = 1; s <= N; s++) begin dly[s] = 2; wrong[s] = 1'b0; end
        run_job(100, 1'b0);
        build_expect();
        total++;
        if (st_cyc.size() !== N || st_cyc[0] !== ex_cyc[0] || st_step[0] !== 1 || dn_cyc.size() !== 1) begin
            bad++;
            $display("FAIL async_reset_restart: got starts=%0d ndone=%0d want starts=%0d ndone=1",
                     st_cyc.size(), dn_cyc.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrong_unit();
        test_timeout();
        test_random_jobs();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
